// File: rtl/data_proc_hls_deadlock_report.sv
// -----------------------------------------------------------------------------
// data_proc_hls_deadlock_report
//
// Purpose:
//   Watches a per-cycle "blocked" indication from an HLS deadlock monitor.
//   A stall episode is counted in stall_cnt. When the episode reaches
//   THRESHOLD consecutive blocked cycles, a sticky deadlock is declared. A
//   one-shot report {cause, stall_cnt} is then offered on a valid/ready port.
//   Shorter episodes are treated as glitches and are dropped silently.
//
// Ports:
//   clock           rising-edge clock for all state
//   reset_n         asynchronous active-low reset
//   block           per-cycle blocked indication
//   axis_block_sigs per-AXIS-channel blocked indications (same cycle as block)
//   clear           single-cycle re-arm pulse
//   deadlock        sticky deadlock-declared flag
//   cause           OR of axis_block_sigs over the current stall episode
//   rpt_valid       report-available strobe
//   rpt_ready       report-consumer acceptance
//   rpt_data        {cause, stall_cnt} captured at deadlock entry
//   event_count     deadlocks declared since reset, saturating at 255
// -----------------------------------------------------------------------------
module data_proc_hls_deadlock_report #(
  parameter int THRESHOLD = 1024,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             block,
  input  logic [1:0]       axis_block_sigs,
  input  logic             clear,
  output logic             deadlock,
  output logic [1:0]       cause,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W+1:0] rpt_data,
  output logic [7:0]       event_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2,
    REPORTED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             deadlock_q, deadlock_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic [CNT_W+1:0] rpt_data_q, rpt_data_d;
  logic [7:0]       event_count_q, event_count_d;

  // Helpers shared by several states.
  logic [CNT_W-1:0] stall_inc;   // plain increment, used while suspecting
  logic [CNT_W-1:0] stall_sat;   // saturating increment, used after declaration
  logic [1:0]       cause_acc;   // cause including this cycle's channel sigs

  always_comb begin
    stall_inc = stall_cnt_q + 1'b1;
    stall_sat = (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q : stall_inc;
    cause_acc = cause_q | axis_block_sigs;
  end

  always_comb begin
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    cause_d       = cause_q;
    deadlock_d    = deadlock_q;
    rpt_valid_d   = rpt_valid_q;
    rpt_data_d    = rpt_data_q;
    event_count_d = event_count_q;

    unique case (state_q)
      IDLE: begin
        // clear wins over block, so a clear cycle never opens an episode.
        if (!clear && block) begin
          state_d     = SUSPECT;
          stall_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
          cause_d     = axis_block_sigs;
        end else begin
          stall_cnt_d = '0;
          cause_d     = '0;
        end
      end

      SUSPECT: begin
        if (clear || !block) begin
          // Either re-armed or the stall was a glitch: drop without report.
          state_d     = IDLE;
          stall_cnt_d = '0;
          cause_d     = '0;
        end else begin
          stall_cnt_d = stall_inc;
          cause_d     = cause_acc;
          if (stall_inc == THR) begin
            state_d       = DEADLOCK;
            deadlock_d    = 1'b1;
            rpt_valid_d   = 1'b1;
            rpt_data_d    = {cause_acc, THR};
            event_count_d = (event_count_q == 8'hFF) ? event_count_q
                                                      : event_count_q + 8'd1;
          end
        end
      end

      DEADLOCK: begin
        // clear is ignored here so the pending report cannot be lost. Since
        // rpt_valid only becomes visible after the entry edge, ready seen on
        // that edge was sampled in SUSPECT and has no effect.
        if (block) begin
          stall_cnt_d = stall_sat;
          cause_d     = cause_acc;
        end
        if (rpt_valid_q && rpt_ready) begin
          state_d     = REPORTED;
          rpt_valid_d = 1'b0;
        end
      end

      REPORTED: begin
        if (clear) begin
          state_d     = IDLE;
          deadlock_d  = 1'b0;
          stall_cnt_d = '0;
          cause_d     = '0;
          rpt_data_d  = '0;
        end else if (block) begin
          stall_cnt_d = stall_sat;
          cause_d     = cause_acc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      stall_cnt_q   <= '0;
      cause_q       <= '0;
      deadlock_q    <= 1'b0;
      rpt_valid_q   <= 1'b0;
      rpt_data_q    <= '0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      cause_q       <= cause_d;
      deadlock_q    <= deadlock_d;
      rpt_valid_q   <= rpt_valid_d;
      rpt_data_q    <= rpt_data_d;
      event_count_q <= event_count_d;
    end
  end

  assign deadlock    = deadlock_q;
  assign cause       = cause_q;
  assign rpt_valid   = rpt_valid_q;
  assign rpt_data    = rpt_data_q;
  assign event_count = event_count_q;

endmodule

// File: doc/data_proc_hls_deadlock_report.md
DATA_PROC_HLS_DEADLOCK_REPORT -- requirements
Module: data_proc_hls_deadlock_report

Interface
REQ-001 Parameter THRESHOLD, default 1024: consecutive blocked cycles that declare a deadlock; legal range 2 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 32: width of the stall-cycle counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 block  in  1  per-cycle blocked indication from the deadlock monitor.
REQ-007 axis_block_sigs  in  2  per-AXIS-channel blocked indications, same cycle as block.
REQ-008 clear  in  1  single-cycle pulse that re-arms the detector.
REQ-009 deadlock  out  1  sticky deadlock-declared flag.
REQ-010 cause  out  2  OR of axis_block_sigs accumulated over the current stall episode.
REQ-011 rpt_valid  out  1  report-available strobe (valid/ready handshake).
REQ-012 rpt_ready  in  1  report-consumer acceptance.
REQ-013 rpt_data  out  CNT_W+2  report payload {cause, stall_cnt}, frozen at deadlock entry.
REQ-014 event_count  out  8  number of deadlocks declared since reset, saturating.

Function
REQ-015 The FSM SHALL have states IDLE, SUSPECT, DEADLOCK and REPORTED; all outputs SHALL be registered.
REQ-016 IDLE, block=1: go to SUSPECT; stall_cnt=1; cause=axis_block_sigs.
REQ-017 IDLE, block=0: stall_cnt=0; cause=0.
REQ-018 SUSPECT, block=1: stall_cnt+=1; cause|=axis_block_sigs; when the new stall_cnt equals THRESHOLD, go to DEADLOCK in that same edge.
REQ-019 SUSPECT, block=0: return to IDLE; stall_cnt=0; cause=0; this is a glitch and no report is produced.
REQ-020 DEADLOCK entry SHALL do all of the following on the same edge:
- set deadlock=1 and rpt_valid=1;
- load rpt_data={cause including the current cycle's sigs, THRESHOLD};
- increment event_count, saturating at 255.
REQ-021 In DEADLOCK, rpt_valid SHALL stay 1 and rpt_data SHALL stay stable until a cycle with rpt_valid=1 and rpt_ready=1; on that edge go to REPORTED and rpt_valid=0.
REQ-022 rpt_ready=1 on the entry edge SHALL have no effect; acceptance is earliest on the cycle after rpt_valid rises, so latency from declaration to report is 1 cycle minimum.
REQ-023 In DEADLOCK and REPORTED, stall_cnt SHALL keep counting while block=1, saturating at 2^CNT_W-1, and cause SHALL keep accumulating; rpt_data SHALL be unaffected.
REQ-024 In DEADLOCK and REPORTED, block falling to 0 SHALL NOT clear deadlock; the flag is sticky.
REQ-025 REPORTED, clear=1: go to IDLE; deadlock=0; stall_cnt=0; cause=0; rpt_data=0; event_count is kept.
REQ-026 DEADLOCK, clear=1: ignore clear, so no report is lost.
REQ-027 IDLE or SUSPECT, clear=1: go to IDLE; stall_cnt=0; cause=0; clear has priority over block in that cycle.
REQ-028 A new stall episode after clear SHALL start from stall_cnt=1 on the first cycle with block=1.

Reset
REQ-029 reset_n=0 SHALL immediately force state=IDLE and set deadlock, cause, rpt_valid, rpt_data, event_count and stall_cnt to 0, independent of clock.
REQ-030 Reset asserted mid-episode or mid-handshake SHALL abandon the episode or report without an event_count increment.
REQ-031 Reset release SHALL be synchronized externally; the first active edge after release evaluates IDLE rules.

Verification (THRESHOLD=8, CNT_W=16)
REQ-032 Glitch filtering:
- Stimulus: block=1 for 7 cycles, then 0.
- Required: deadlock stays 0, rpt_valid stays 0, event_count=0, cause returns to 0.
REQ-033 Deadlock declaration:
- Stimulus: block=1 for 8 cycles, with axis_block_sigs=01 on cycles 1-4 and 10 on cycles 5-8.
- Required: deadlock=1 and rpt_valid=1 after the 8th edge; rpt_data={2'b11,16'd8}; event_count=1.
REQ-034 Report back-pressure:
- Stimulus: rpt_ready=0 for 20 cycles with block still 1, then rpt_ready=1.
- Required: rpt_data constant at {11,8}; rpt_valid drops 1 cycle after acceptance; stall_cnt=28; deadlock stays 1.
REQ-035 Clear ordering:
- Stimulus: clear pulse in DEADLOCK before acceptance, then accept, then clear.
- Required: the first clear is ignored; after the second, deadlock=0 and event_count stays 1.
REQ-036 Reset mid-operation:
- Stimulus: reset_n=0 asserted asynchronously mid-SUSPECT (stall_cnt=5), and again with rpt_valid=1.
- Required: all outputs 0 without waiting for a clock edge; no report follows release.
REQ-037 Saturation:
- Stimulus: 300 deadlock/accept/clear cycles.
- Required: event_count saturates at 255.
